dm_framer: RTL and testbench

- Byte-to-serial frame transmitter that sits upstream of the differential Manchester encoder.
- Accepts a frame request (length) plus payload bytes over a valid/ready handshake.
- Drives tx_sdata bit-by-bit on the encoder's tx_ce strobe, in this order: preamble, sync byte, length, payload, CRC-8.
- It is the transmit-side counterpart of the receive-side deframer that consumes decoder rx_sdata/rx_ce.

---
 rtl/dm_framer.sv | 199 +++++++++++++++++++
 tb/tb_dm_framer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_framer.sv
// dm_framer: serialises preamble, sync, length, payload and CRC-8 onto
// tx_sdata, one bit per tx_ce strobe, MSB first, with no gap between bytes.
module dm_framer #(
    parameter int         PREAMBLE_BYTES = 2,
    parameter logic [7:0] SYNC_BYTE      = 8'hD5,
    parameter logic       IDLE_BIT       = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tx_ce_i,
    input  logic       frame_start_i,
    input  logic [7:0] frame_len_i,
    input  logic [7:0] s_data_i,
    input  logic       s_valid_i,
    output logic       s_ready_o,
    output logic       tx_sdata_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       underrun_o
);

    localparam logic [3:0] PRE_N    = 4'(PREAMBLE_BYTES);
    localparam logic [7:0] PRE_BYTE = 8'hAA;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SYNC,
        S_LEN,
        S_PAY,
        S_CRC
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [3:0] precnt_q, precnt_d;     // preamble bytes loaded so far
    logic [7:0] len_q, len_d;
    logic [7:0] paycnt_q, paycnt_d;     // payload slots loaded so far
    logic [8:0] acc_q, acc_d;           // bytes accepted plus substituted slots
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] crc_q, crc_d;
    logic       underrun_q, underrun_d;
    logic       done_q, done_d;

    logic       busy;
    logic       xfer;
    logic       byte_end;
    logic       pay_done;
    logic [7:0] pay_byte;

    // CRC-8, poly 0x07, one whole byte folded in at a time
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    assign busy       = (state_q != S_IDLE);
    assign busy_o     = busy;
    assign done_o     = done_q;
    assign underrun_o = underrun_q;
    assign tx_sdata_o = busy ? shreg_q[7] : IDLE_BIT;
    assign s_ready_o  = busy & ~hold_full_q & (acc_q < {1'b0, len_q});
    assign xfer       = s_valid_i & s_ready_o;
    assign byte_end   = busy & tx_ce_i & (bitcnt_q == 3'd7);
    // Leaving LEN with zero length, or the last payload slot already loaded
    assign pay_done   = (state_q == S_LEN) ? (len_q == 8'd0) : (paycnt_q == len_q);

    // Next-state and datapath: shifting, byte loads, hold register, CRC
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        precnt_d    = precnt_q;
        len_d       = len_q;
        paycnt_d    = paycnt_q;
        acc_d       = acc_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        crc_d       = crc_q;
        underrun_d  = underrun_q;
        done_d      = 1'b0;
        pay_byte    = 8'h00;

        // Handshake into the hold register; s_ready already excludes a full hold
        if (xfer) begin
            hold_d      = s_data_i;
            hold_full_d = 1'b1;
            acc_d       = acc_q + 9'd1;
        end

        if (state_q == S_IDLE) begin
            if (frame_start_i) begin
                len_d       = frame_len_i;
                underrun_d  = 1'b0;
                shreg_d     = PRE_BYTE;
                bitcnt_d    = 3'd0;
                precnt_d    = 4'd1;
                paycnt_d    = 8'd0;
                acc_d       = 9'd0;
                hold_full_d = 1'b0;
                crc_d       = 8'h00;
                state_d     = S_PRE;
            end
        end else if (tx_ce_i) begin
            shreg_d  = {shreg_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q + 3'd1;
            // Last bit of a byte: the following byte loads on this same edge
            if (byte_end) begin
                unique case (state_q)
                    S_PRE: begin
                        if (precnt_q == PRE_N) begin
                            shreg_d = SYNC_BYTE;
                            state_d = S_SYNC;
                        end else begin
                            shreg_d  = PRE_BYTE;
                            precnt_d = precnt_q + 4'd1;
                        end
                    end
                    S_SYNC: begin
                        shreg_d = len_q;
                        crc_d   = crc8_byte(8'h00, len_q);
                        state_d = S_LEN;
                    end
                    S_LEN, S_PAY: begin
                        if (pay_done) begin
                            // A starved frame is poisoned by inverting its CRC
                            shreg_d = underrun_q ? ~crc_q : crc_q;
                            state_d = S_CRC;
                        end else begin
                            if (hold_full_q) begin
                                pay_byte    = hold_q;
                                hold_full_d = 1'b0;
                            end else begin
                                pay_byte   = 8'h00;
                                underrun_d = 1'b1;
                                acc_d      = acc_d + 9'd1;
                            end
                            shreg_d  = pay_byte;
                            crc_d    = crc8_byte(crc_q, pay_byte);
                            paycnt_d = paycnt_q + 8'd1;
                            state_d  = S_PAY;
                        end
                    end
                    S_CRC: begin
                        shreg_d = 8'h00;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg_q     <= 8'h00;
            bitcnt_q    <= 3'd0;
            precnt_q    <= 4'd0;
            len_q       <= 8'd0;
            paycnt_q    <= 8'd0;
            acc_q       <= 9'd0;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            crc_q       <= 8'h00;
            underrun_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            precnt_q    <= precnt_d;
            len_q       <= len_d;
            paycnt_q    <= paycnt_d;
            acc_q       <= acc_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            crc_q       <= crc_d;
            underrun_q  <= underrun_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_dm_framer.sv
// tb_dm_framer: vector table plus random frames, checked against a
// frame-level model (expected byte list, bit-serial CRC).
module tb_dm_framer;

    localparam int P = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_ce, frame_start, s_valid;
    logic [7:0] frame_len, s_data;
    logic       s_ready_o, tx_sdata_o, busy_o, done_o, underrun_o;

    int n_cmp = 0;
    int n_err = 0;

    int         bits[$];
    logic [7:0] acc[$];
    int         done_cnt;

    typedef struct {
        int len;
        int gap;       // tx_ce period in clk
        int vmode;     // 0 always valid, 1 never, 2 toggle, 3 random (refilled often)
        bit fix0;      // present 0x00 as data
        int exp_crc;   // expected on-wire CRC byte, -1 = model only
        bit start_mid; // pulse frame_start during frame and on last CRC strobe
        bit exp_ur;
    } vec_t;

    vec_t vecs[7];

    dm_framer #(.PREAMBLE_BYTES(P), .SYNC_BYTE(8'hD5), .IDLE_BIT(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .tx_ce_i(tx_ce), .frame_start_i(frame_start),
        .frame_len_i(frame_len), .s_data_i(s_data), .s_valid_i(s_valid),
        .s_ready_o(s_ready_o), .tx_sdata_o(tx_sdata_o), .busy_o(busy_o),
        .done_o(done_o), .underrun_o(underrun_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Reference CRC: message treated as one serial bit stream
    function automatic logic [7:0] crc_model(input logic [7:0] msg[$]);
        logic [7:0] r;
        logic       fb;
        r = 8'h00;
        foreach (msg[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = r[7] ^ msg[i][b];
                r  = {r[6:0], 1'b0};
                if (fb) r = r ^ 8'h07;
            end
        end
        return r;
    endfunction

    // One clock: inputs already set at negedge; note what the DUT takes on the edge
    task automatic step();
        if (tx_ce && busy_o) bits.push_back(int'(tx_sdata_o));
        if (s_valid && s_ready_o) acc.push_back(s_data);
        @(posedge clk);
        @(negedge clk);
        if (done_o) done_cnt++;
    endtask

    task automatic idle_inputs();
        tx_ce = 0; frame_start = 0; s_valid = 0; s_data = 0; frame_len = 0;
    endtask

    task automatic run_frame(input vec_t v);
        int total, cyc, budget, busy_drop, nb, mism, first_bad;
        logic [7:0] exp_q[$];
        logic [7:0] crcm, rx;
        bits.delete(); acc.delete(); done_cnt = 0;
        total  = (P + 3 + v.len) * 8;
        budget = total * v.gap + 200;
        busy_drop = 0;

        idle_inputs();
        frame_start = 1; frame_len = 8'(v.len);
        step();
        frame_start = 0;
        chk("busy_after_start", int'(busy_o), 1);
        chk("underrun_cleared", int'(underrun_o), 0);

        cyc = 0;
        while (done_cnt == 0 && cyc < budget) begin
            tx_ce = ((cyc % v.gap) == v.gap - 1);
            case (v.vmode)
                0: s_valid = 1;
                1: s_valid = 0;
                2: s_valid = cyc[0];
                default: s_valid = ($urandom_range(0, 1) == 1) || (cyc % 4 == 0);
            endcase
            s_data = v.fix0 ? 8'h00 : 8'($urandom);
            frame_start = v.start_mid && ((tx_ce && bits.size() == total - 1) || (cyc % 37 == 5));
            frame_len = 8'($urandom);
            if (!busy_o) busy_drop++;
            step();
            cyc++;
        end
        if (done_cnt == 0) chk("done_timeout", cyc, -1);
        chk("busy_held", busy_drop, 0);

        // Idle strobes after the frame must change nothing
        idle_inputs();
        tx_ce = 1;
        for (int i = 0; i < 4; i++) step();
        tx_ce = 0;
        chk("single_done", done_cnt, 1);
        chk("busy_after_done", int'(busy_o), 0);
        chk("idle_bit", int'(tx_sdata_o), 0);
        chk("underrun_flag", int'(underrun_o), int'(v.exp_ur));
        chk("ce_count", bits.size(), total);

        // Expected frame from the byte-level rules
        for (int i = 0; i < P; i++) exp_q.push_back(8'hAA);
        exp_q.push_back(8'hD5);
        exp_q.push_back(8'(v.len));
        if (v.vmode == 1) begin
            for (int i = 0; i < v.len; i++) exp_q.push_back(8'h00);
            chk("accepted_count", acc.size(), 0);
        end else begin
            foreach (acc[i]) exp_q.push_back(acc[i]);
            chk("accepted_count", acc.size(), v.len);
        end
        crcm = crc_model(exp_q[P+1:$]);
        exp_q.push_back(v.exp_ur ? ~crcm : crcm);

        nb = bits.size() / 8;
        mism = 0; first_bad = -1; rx = 0;
        for (int i = 0; i < nb; i++) begin
            rx = 0;
            for (int b = 0; b < 8; b++) rx = {rx[6:0], bits[i*8+b][0]};
            if (i >= exp_q.size() || rx != exp_q[i]) begin
                mism++;
                if (first_bad < 0) first_bad = i;
            end
        end
        if (mism != 0) $display("FAIL frame_bytes: first bad byte index %0d of len %0d", first_bad, v.len);
        chk("frame_bytes_mismatches", mism, 0);
        if (v.exp_crc >= 0) chk("crc_on_wire", int'(rx), v.exp_crc);
    endtask

    initial begin
        vec_t rv;
        int   tgt;
        vecs[0] = '{len: 0,   gap: 50, vmode: 0, fix0: 0, exp_crc: 8'h00, start_mid: 0, exp_ur: 0};
        vecs[1] = '{len: 1,   gap: 50, vmode: 0, fix0: 1, exp_crc: 8'h15, start_mid: 0, exp_ur: 0};
        vecs[2] = '{len: 1,   gap: 10, vmode: 1, fix0: 0, exp_crc: 8'hEA, start_mid: 0, exp_ur: 1};
        vecs[3] = '{len: 4,   gap: 1,  vmode: 2, fix0: 0, exp_crc: -1,    start_mid: 0, exp_ur: 0};
        vecs[4] = '{len: 3,   gap: 4,  vmode: 1, fix0: 0, exp_crc: -1,    start_mid: 1, exp_ur: 1};
        vecs[5] = '{len: 6,   gap: 3,  vmode: 0, fix0: 0, exp_crc: -1,    start_mid: 1, exp_ur: 0};
        vecs[6] = '{len: 255, gap: 1,  vmode: 0, fix0: 0, exp_crc: -1,    start_mid: 0, exp_ur: 0};

        rst_n = 0;
        idle_inputs();
        #2;
        chk("rst_tx_sdata", int'(tx_sdata_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_underrun", int'(underrun_o), 0);
        chk("rst_s_ready", int'(s_ready_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        foreach (vecs[i]) run_frame(vecs[i]);

        // Reset in the middle of the payload
        bits.delete(); acc.delete(); done_cnt = 0;
        frame_start = 1; frame_len = 8'd8;
        step();
        frame_start = 0;
        tgt = (P + 3) * 8 + 12;
        for (int c = 0; c < 400 && bits.size() < tgt; c++) begin
            tx_ce = c[0]; s_valid = 1; s_data = 8'($urandom);
            step();
        end
        chk("in_payload_before_reset", int'(bits.size() >= tgt), 1);
        rst_n = 0;
        #1;
        chk("async_rst_tx_sdata", int'(tx_sdata_o), 0);
        chk("async_rst_busy", int'(busy_o), 0);
        chk("async_rst_s_ready", int'(s_ready_o), 0);
        @(negedge clk);
        step();
        step();
        chk("no_done_on_reset", done_cnt, 0);
        idle_inputs();
        rst_n = 1;
        step();

        // Random frames
        for (int k = 0; k < 8; k++) begin
            rv = '{len: $urandom_range(0, 40), gap: $urandom_range(2, 5), vmode: 3,
                   fix0: 0, exp_crc: -1, start_mid: ($urandom_range(0, 1) == 1), exp_ur: 0};
            run_frame(rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
